// File: rtl/hm2_board_io_pkg.sv
// Shared definitions for the HostMot2 board I/O mapper: register map, header modes and
// the read-only geometry word.
package hm2_board_io_pkg;

    localparam logic [2:0] ADDR_NAME_LOW  = 3'd0;
    localparam logic [2:0] ADDR_NAME_HIGH = 3'd1;
    localparam logic [2:0] ADDR_GEOMETRY  = 3'd2;
    localparam logic [2:0] ADDR_MODE      = 3'd3;
    localparam logic [2:0] ADDR_RELOAD    = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    typedef enum logic {
        STRAIGHT = 1'b0,
        DB25     = 1'b1
    } mode_e;

    localparam int unsigned DB25_PINS = 17;

    function automatic logic [31:0] pack_geometry(input int unsigned num_gpio,
                                                  input int unsigned sync_stages,
                                                  input int unsigned mux_w,
                                                  input int unsigned gpio_width);
        logic [31:0] g;
        g[31:24] = 8'(num_gpio);
        g[23:16] = 8'(sync_stages);
        g[15:8]  = 8'(mux_w);
        g[7:0]   = 8'(gpio_width);
        return g;
    endfunction

endpackage

// File: rtl/hm2_header_map.sv
// One physical header: STRAIGHT/DB25 pin mapping, break-before-make drain FSM and the
// input synchroniser whose last stage also performs the pin-to-io demux.
module hm2_header_map
    import hm2_board_io_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 36,
    parameter int unsigned MUX_W       = 36,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BBM_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode_wr,
    input  logic                  remap,
    input  logic                  new_db25,
    input  logic                  force_off,
    input  logic [MUX_W-1:0]      io_out,
    input  logic [MUX_W-1:0]      io_oe,
    output logic [MUX_W-1:0]      io_in,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe
);

    localparam int unsigned HALF = GPIO_WIDTH / 2;
    localparam int unsigned CNT_W = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BBM_CYCLES - 1);

    typedef enum logic {
        StActive = 1'b0,
        StDrain  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q;

    logic [GPIO_WIDTH-1:0] s_out, s_oe, d_out, d_oe;
    logic [GPIO_WIDTH-1:0] out_q, oe_q;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES-1];
    logic [GPIO_WIDTH-1:0] sync_last;
    logic [MUX_W-1:0]      s_in, d_in, io_in_q;

    // Unmapped pins tie to 0 in both modes, so the mux below needs no extra qualifier.
    for (genvar p = 0; p < GPIO_WIDTH; p++) begin : g_pin
        localparam int unsigned J    = p / HALF;
        localparam int unsigned K    = p % HALF;
        localparam int unsigned DIDX = J * DB25_PINS + K;
        if (p < MUX_W) begin : g_s
            assign s_out[p] = io_out[p];
            assign s_oe[p]  = io_oe[p];
        end else begin : g_s_nc
            assign s_out[p] = 1'b0;
            assign s_oe[p]  = 1'b0;
        end
        if (K < DB25_PINS && DIDX < MUX_W) begin : g_d
            assign d_out[p] = io_out[DIDX];
            assign d_oe[p]  = io_oe[DIDX];
        end else begin : g_d_nc
            assign d_out[p] = 1'b0;
            assign d_oe[p]  = 1'b0;
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-2];

    for (genvar i = 0; i < MUX_W; i++) begin : g_io
        localparam int unsigned J   = i / DB25_PINS;
        localparam int unsigned K   = i % DB25_PINS;
        localparam int unsigned PIN = J * HALF + K;
        if (i < GPIO_WIDTH) begin : g_s
            assign s_in[i] = sync_last[i];
        end else begin : g_s_nc
            assign s_in[i] = 1'b0;
        end
        if (J < 2 && K < HALF) begin : g_d
            assign d_in[i] = sync_last[PIN];
        end else begin : g_d_nc
            assign d_in[i] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StActive: begin
                if (remap) begin
                    state_d = StDrain;
                    cnt_d   = CNT_LOAD;
                end
            end
            StDrain: begin
                if (remap || mode_wr) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StActive;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StActive;
            cnt_q   <= '0;
            mode_q  <= STRAIGHT;
            out_q   <= '0;
            oe_q    <= '0;
            io_in_q <= '0;
            for (int s = 0; s < int'(SYNC_STAGES) - 1; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (mode_wr) begin
                mode_q <= new_db25 ? DB25 : STRAIGHT;
            end
            out_q   <= (mode_q == DB25) ? d_out : s_out;
            oe_q    <= (mode_q == DB25) ? d_oe : s_oe;
            io_in_q <= (mode_q == DB25) ? d_in : s_in;
            sync_q[0] <= gpio_in;
            for (int s = 1; s < int'(SYNC_STAGES) - 1; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign io_in    = io_in_q;
    assign gpio_out = force_off ? '0 : out_q;
    assign gpio_oe  = (force_off || state_q == StDrain) ? '0 : oe_q;

endmodule

// File: rtl/hm2_board_io_mux.sv
// Bus-programmable board I/O mapper between the hm2 flat I/O vector and the GPIO headers,
// with a host watchdog that forces all pads safe when the host stops writing.
module hm2_board_io_mux
    import hm2_board_io_pkg::*;
#(
    parameter int unsigned NUM_GPIO        = 2,
    parameter int unsigned GPIO_WIDTH      = 36,
    parameter int unsigned IO_WIDTH        = 72,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned BBM_CYCLES      = 4,
    parameter logic [31:0] BOARD_NAME_LOW  = 32'h4153454D,
    parameter logic [31:0] BOARD_NAME_HIGH = 32'h35324935
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [2:0]                     bus_addr,
    input  logic                           bus_wr,
    input  logic                           bus_rd,
    input  logic [31:0]                    bus_wdata,
    output logic [31:0]                    bus_rdata,
    input  logic [IO_WIDTH-1:0]            io_out,
    input  logic [IO_WIDTH-1:0]            io_oe,
    output logic [IO_WIDTH-1:0]            io_in,
    input  logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_in,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_out,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_oe,
    output logic                           wdt_expired
);

    localparam int unsigned MUX_W = IO_WIDTH / NUM_GPIO;
    localparam int unsigned USED_W = NUM_GPIO * MUX_W;
    localparam logic [31:0] GEOMETRY = pack_geometry(NUM_GPIO, SYNC_STAGES, MUX_W, GPIO_WIDTH);
    localparam logic [31:0] MODE_MASK = 32'h8000_0000 | ((32'd1 << NUM_GPIO) - 32'd1);

    logic [31:0] mode_q, reload_q, cnt_q, cnt_d, rdata_q, rdata_d;
    logic        expired_q, expired_d;
    logic        mode_wr, w1c, expire_now, force_off;
    logic [NUM_GPIO-1:0] remap;

    assign mode_wr    = bus_wr && (bus_addr == ADDR_MODE);
    assign w1c        = bus_wr && (bus_addr == ADDR_STATUS) && bus_wdata[0];
    assign expire_now = (cnt_q == 32'd1);
    assign force_off  = expired_q || !mode_q[31];

    always_comb begin
        cnt_d = cnt_q;
        if (bus_wr) begin
            cnt_d = (bus_addr == ADDR_RELOAD) ? bus_wdata : reload_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 32'd1;
        end
        // An expiry landing on the same edge as a W1C must not be lost.
        expired_d = expire_now || (expired_q && !w1c);
    end

    always_comb begin
        rdata_d = '0;
        case (bus_addr)
            ADDR_NAME_LOW:  rdata_d = BOARD_NAME_LOW;
            ADDR_NAME_HIGH: rdata_d = BOARD_NAME_HIGH;
            ADDR_GEOMETRY:  rdata_d = GEOMETRY;
            ADDR_MODE:      rdata_d = mode_q;
            ADDR_RELOAD:    rdata_d = reload_q;
            ADDR_STATUS:    rdata_d = {31'd0, expired_q};
            default:        rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= '0;
            reload_q  <= '0;
            cnt_q     <= '0;
            expired_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (mode_wr) begin
                mode_q <= bus_wdata & MODE_MASK;
            end
            if (bus_wr && bus_addr == ADDR_RELOAD) begin
                reload_q <= bus_wdata;
            end
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            if (bus_rd) begin
                rdata_q <= rdata_d;
            end
        end
    end

    for (genvar h = 0; h < NUM_GPIO; h++) begin : g_hdr
        assign remap[h] = mode_wr &&
                          ((bus_wdata[h] != mode_q[h]) || (bus_wdata[31] != mode_q[31]));

        hm2_header_map #(
            .GPIO_WIDTH  (GPIO_WIDTH),
            .MUX_W       (MUX_W),
            .SYNC_STAGES (SYNC_STAGES),
            .BBM_CYCLES  (BBM_CYCLES)
        ) u_hdr (
            .clk       (clk),
            .reset_n   (reset_n),
            .mode_wr   (mode_wr),
            .remap     (remap[h]),
            .new_db25  (bus_wdata[h]),
            .force_off (force_off),
            .io_out    (io_out[h*MUX_W +: MUX_W]),
            .io_oe     (io_oe[h*MUX_W +: MUX_W]),
            .io_in     (io_in[h*MUX_W +: MUX_W]),
            .gpio_in   (gpio_in[h*GPIO_WIDTH +: GPIO_WIDTH]),
            .gpio_out  (gpio_out[h*GPIO_WIDTH +: GPIO_WIDTH]),
            .gpio_oe   (gpio_oe[h*GPIO_WIDTH +: GPIO_WIDTH])
        );
    end

    if (IO_WIDTH > USED_W) begin : g_io_pad
        assign io_in[IO_WIDTH-1:USED_W] = '0;
    end

    assign bus_rdata   = rdata_q;
    assign wdt_expired = expired_q;

endmodule

// File: tb/tb_hm2_board_io_mux.sv
// Directed bench for hm2_board_io_mux: register map, STRAIGHT/DB25 mapping, drain timing,
// watchdog expiry and W1C race, input synchroniser latency and async reset.
module tb_hm2_board_io_mux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  bus_addr;
    logic        bus_wr, bus_rd;
    logic [31:0] bus_wdata, bus_rdata;
    logic [71:0] io_out, io_oe, io_in;
    logic [71:0] gpio_in, gpio_out, gpio_oe;
    logic        wdt_expired;

    int n_checks = 0;
    int n_pass   = 0;

    hm2_board_io_mux dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_addr    (bus_addr),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .io_out      (io_out),
        .io_oe       (io_oe),
        .io_in       (io_in),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .wdt_expired (wdt_expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = 1'b1;
        tick();
        bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        bus_addr = a;
        bus_rd   = 1'b1;
        tick();
        bus_rd   = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        bus_addr  = '0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_wdata = '0;
        io_out    = '0;
        io_oe     = '0;
        gpio_in   = '0;
        repeat (3) tick();
        check("rst_rdata", 72'(bus_rdata), 72'h0);
        check("rst_oe", gpio_oe, 72'h0);
        check("rst_out", gpio_out, 72'h0);
        check("rst_io_in", io_in, 72'h0);
        check("rst_wdt", 72'(wdt_expired), 72'h0);
        reset_n = 1'b1;
        tick();

        bus_read(3'd0);
        check("rd_name_lo", 72'(bus_rdata), 72'h4153454D);
        bus_read(3'd1);
        check("rd_name_hi", 72'(bus_rdata), 72'h35324935);
        bus_read(3'd2);
        check("rd_geometry", 72'(bus_rdata), 72'h02022424);
        repeat (2) tick();
        check("rdata_hold", 72'(bus_rdata), 72'h02022424);
        bus_read(3'd3);
        check("rd_mode_rst", 72'(bus_rdata), 72'h0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6);
        check("rd_addr6", 72'(bus_rdata), 72'h0);

        // Global enable: every header drains for 4 cycles, then STRAIGHT pass-through.
        io_oe  = '1;
        io_out = 72'h20;
        bus_write(3'd3, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            check("en_drain_oe", gpio_oe, 72'h0);
            tick();
        end
        check("en_active_oe", gpio_oe, {72{1'b1}});
        check("en_out5", gpio_out, 72'h20);
        io_out = 72'h40;
        check("out_pre_edge", gpio_out, 72'h20);
        tick();
        check("out_post_edge", gpio_out, 72'h40);

        // Header0 to DB25: only header0 drains.
        io_out = 72'h2_0000;
        bus_write(3'd3, 32'h8000_0001);
        for (int i = 0; i < 4; i++) begin
            check("db25_drain_h0", 72'(gpio_oe[35:0]), 72'h0);
            check("db25_h1_live", 72'(gpio_oe[71:36]), 72'hF_FFFF_FFFF);
            tick();
        end
        check("db25_oe_h0", 72'(gpio_oe[35:0]), 72'h7_FFFD_FFFF);
        check("db25_out_h0", 72'(gpio_out[35:0]), 72'h4_0000);
        check("db25_out_h1", 72'(gpio_out[71:36]), 72'h0);
        bus_read(3'd3);
        check("rd_mode", 72'(bus_rdata), 72'h8000_0001);

        // Watchdog expiry 10 cycles after the reload write.
        bus_write(3'd4, 32'd10);
        repeat (9) tick();
        check("wdt_before", 72'(wdt_expired), 72'h0);
        tick();
        check("wdt_expired", 72'(wdt_expired), 72'h1);
        check("wdt_oe_off", gpio_oe, 72'h0);
        check("wdt_out_off", gpio_out, 72'h0);
        bus_write(3'd5, 32'h1);
        check("w1c_clear", 72'(wdt_expired), 72'h0);
        check("w1c_oe_back", gpio_oe, {36'hF_FFFF_FFFF, 36'h7_FFFD_FFFF});
        repeat (9) tick();
        check("race_before", 72'(wdt_expired), 72'h0);
        bus_write(3'd5, 32'h1);
        check("race_expiry_wins", 72'(wdt_expired), 72'h1);
        bus_read(3'd5);
        check("rd_status", 72'(bus_rdata), 72'h1);
        bus_write(3'd4, 32'd0);
        bus_write(3'd5, 32'h1);
        repeat (15) tick();
        check("wdt_disabled", 72'(wdt_expired), 72'h0);

        // Input synchroniser: header1 STRAIGHT pin 4 -> io 40.
        gpio_in = 72'h1 << 40;
        tick();
        check("sync_rise_1", 72'(io_in[40]), 72'h0);
        tick();
        check("sync_rise_2", 72'(io_in[40]), 72'h1);
        gpio_in = '0;
        tick();
        check("sync_fall_1", 72'(io_in[40]), 72'h1);
        tick();
        check("sync_fall_2", 72'(io_in[40]), 72'h0);
        // Header0 DB25: pin 18 -> io 17; pins 17 and 35 unused.
        gpio_in = (72'h1 << 17) | (72'h1 << 18) | (72'h1 << 35);
        repeat (2) tick();
        check("db25_in_h0", 72'(io_in[35:0]), 72'h2_0000);

        // Reset while header0 drains.
        gpio_in = 72'h1 << 40;
        bus_write(3'd3, 32'h8000_0000);
        tick();
        check("pre_rst_h0_drain", 72'(gpio_oe[35:0]), 72'h0);
        check("pre_rst_h1_live", 72'(gpio_oe[71:36]), 72'hF_FFFF_FFFF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_oe", gpio_oe, 72'h0);
        check("async_rst_out", gpio_out, 72'h0);
        check("async_rst_io_in", io_in, 72'h0);
        check("async_rst_rdata", 72'(bus_rdata), 72'h0);
        tick();
        reset_n = 1'b1;
        tick();
        bus_read(3'd3);
        check("post_rst_mode", 72'(bus_rdata), 72'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
